// File: rtl/seg_pkg.sv
// Shared types and constants for the 7-segment scan controller slice.
package seg_pkg;

  localparam int NIB_W = 4;
  localparam int SEG_W = 7;

  typedef enum logic [1:0] {
    OFF   = 2'd0,
    BLANK = 2'd1,
    SHOW  = 2'd2
  } seg_state_e;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/seg_scan_ctrl_if.sv
// Display-image write port: producer offers a full image, controller accepts when its
// pending buffer is free.
interface seg_scan_ctrl_if #(
  parameter int NDIG = 8
);
  logic                          wr_valid;
  logic                          wr_ready;
  logic [seg_pkg::NIB_W*NDIG-1:0] wr_data;
  logic [NDIG-1:0]               wr_mask;

  modport master (output wr_valid, output wr_data, output wr_mask, input wr_ready);
  modport slave  (input wr_valid, input wr_data, input wr_mask, output wr_ready);
endinterface

// File: rtl/seg_scan_ctrl_chk.sv
// Panel-safety checks on the digit selects: never multi-hot, and a blanking gap of at
// least BLANK_CYC idle cycles before a different digit is driven.
module seg_scan_ctrl_chk #(
  parameter int NDIG      = 8,
  parameter int BLANK_CYC = 16
) (
  input logic            clk,
  input logic            rst,
  input logic [NDIG-1:0] dig_sel
);
  logic [NDIG-1:0] last_sel_r;
  logic [15:0]     zero_run_r;

  // Track the last driven select and the length of the idle run since it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_sel_r <= {NDIG{1'b0}};
      zero_run_r <= 16'd0;
    end else if (dig_sel == {NDIG{1'b0}}) begin
      if (zero_run_r != 16'hFFFF) begin
        zero_run_r <= zero_run_r + 16'd1;
      end
    end else begin
      last_sel_r <= dig_sel;
      zero_run_r <= 16'd0;
    end
  end

  a_sel_onehot0: assert property (@(posedge clk) disable iff (rst) $onehot0(dig_sel));

  a_blank_gap: assert property (@(posedge clk) disable iff (rst)
    ((dig_sel != {NDIG{1'b0}}) && (last_sel_r != {NDIG{1'b0}}) && (dig_sel != last_sel_r))
      |-> (zero_run_r >= 16'(BLANK_CYC)));
endmodule

// File: rtl/seg_slot_timer.sv
// Loadable down-counter timing one blank or show slot; tc is high while the count is zero.
module seg_slot_timer #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             tc
);
  logic [CNT_W-1:0] cnt_r;

  // Count register: clear wins over load, otherwise decrement and park at zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if (clr) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if (load) begin
      cnt_r <= load_val;
    end else if (cnt_r != {CNT_W{1'b0}}) begin
      cnt_r <= cnt_r - CNT_W'(1'b1);
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign tc = (cnt_r == {CNT_W{1'b0}});
endmodule

// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed scan of an NDIG-digit 7-segment panel through one shared decoder, with
// blanking gaps between digits and a double-buffered image swapped only at frame ends.
module seg_scan_ctrl
  import seg_pkg::*;
#(
  parameter int NDIG      = 8,
  parameter int SHOW_CYC  = 1000,
  parameter int BLANK_CYC = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  seg_scan_ctrl_if.slave   wr,
  output logic [NIB_W-1:0] dec_nib,
  output logic [NDIG-1:0]  dig_sel,
  output logic             frame_done
);
  localparam int IDX_W = $clog2(NDIG);
  localparam int CNT_W = $clog2(max_int(SHOW_CYC, BLANK_CYC) + 1);
  localparam int DAT_W = NIB_W * NDIG;
  localparam logic [CNT_W-1:0] BLANK_LD = CNT_W'(BLANK_CYC - 1);
  localparam logic [CNT_W-1:0] SHOW_LD  = CNT_W'(SHOW_CYC - 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NDIG - 1);
  localparam logic [NDIG-1:0]  SEL_ONE  = NDIG'(1'b1);

  seg_state_e       state_r;
  logic [IDX_W-1:0] idx_r;
  logic [DAT_W-1:0] act_data_r;
  logic [DAT_W-1:0] pend_data_r;
  logic [NDIG-1:0]  act_mask_r;
  logic [NDIG-1:0]  pend_mask_r;
  logic             pend_full_r;
  logic             wr_ready_r;
  logic [NIB_W-1:0] dec_nib_r;
  logic [NDIG-1:0]  dig_sel_r;
  logic             frame_done_r;

  logic             tmr_clr_s;
  logic             tmr_load_s;
  logic [CNT_W-1:0] tmr_val_s;
  logic             tmr_tc_s;
  logic             boundary_s;
  logic             accept_s;
  logic             commit_s;

  // The last show cycle of the last digit is the only point where the image may swap.
  assign boundary_s = en & (state_r == SHOW) & tmr_tc_s & (idx_r == LAST_IDX);
  assign accept_s   = wr.wr_valid & wr_ready_r;
  assign commit_s   = boundary_s & pend_full_r;

  // Slot timer control: reload on every slot transition, hold at zero while dark.
  always_comb begin
    tmr_clr_s  = 1'b0;
    tmr_load_s = 1'b0;
    tmr_val_s  = BLANK_LD;
    if (!en) begin
      tmr_clr_s = 1'b1;
    end else begin
      case (state_r)
        OFF: begin
          tmr_load_s = 1'b1;
          tmr_val_s  = BLANK_LD;
        end
        BLANK: begin
          if (tmr_tc_s) begin
            tmr_load_s = 1'b1;
            tmr_val_s  = SHOW_LD;
          end else begin
            tmr_load_s = 1'b0;
          end
        end
        SHOW: begin
          if (tmr_tc_s) begin
            tmr_load_s = 1'b1;
            tmr_val_s  = BLANK_LD;
          end else begin
            tmr_load_s = 1'b0;
          end
        end
        default: tmr_clr_s = 1'b1;
      endcase
    end
  end

  seg_slot_timer #(.CNT_W(CNT_W)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .clr      (tmr_clr_s),
    .load     (tmr_load_s),
    .load_val (tmr_val_s),
    .tc       (tmr_tc_s)
  );

  // Double buffer: accept needs an empty pending slot, so it can never meet a commit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      act_data_r  <= {DAT_W{1'b0}};
      act_mask_r  <= {NDIG{1'b0}};
      pend_data_r <= {DAT_W{1'b0}};
      pend_mask_r <= {NDIG{1'b0}};
      pend_full_r <= 1'b0;
      wr_ready_r  <= 1'b1;
    end else if (commit_s) begin
      act_data_r  <= pend_data_r;
      act_mask_r  <= pend_mask_r;
      pend_full_r <= 1'b0;
      wr_ready_r  <= 1'b1;
    end else if (accept_s) begin
      pend_data_r <= wr.wr_data;
      pend_mask_r <= wr.wr_mask;
      pend_full_r <= 1'b1;
      wr_ready_r  <= 1'b0;
    end
  end

  // Scan FSM with registered panel outputs; masked digits still consume their slot.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r      <= OFF;
      idx_r        <= IDX_W'(1'b0);
      dec_nib_r    <= {NIB_W{1'b0}};
      dig_sel_r    <= {NDIG{1'b0}};
      frame_done_r <= 1'b0;
    end else begin
      frame_done_r <= 1'b0;
      if (!en) begin
        state_r   <= OFF;
        idx_r     <= IDX_W'(1'b0);
        dig_sel_r <= {NDIG{1'b0}};
      end else begin
        case (state_r)
          OFF: state_r <= BLANK;
          BLANK: begin
            if (tmr_tc_s) begin
              state_r   <= SHOW;
              dec_nib_r <= act_data_r[idx_r*NIB_W +: NIB_W];
              dig_sel_r <= act_mask_r[idx_r] ? (SEL_ONE << idx_r) : {NDIG{1'b0}};
            end
          end
          SHOW: begin
            if (tmr_tc_s) begin
              state_r   <= BLANK;
              dig_sel_r <= {NDIG{1'b0}};
              if (idx_r == LAST_IDX) begin
                idx_r        <= IDX_W'(1'b0);
                frame_done_r <= 1'b1;
              end else begin
                idx_r <= idx_r + IDX_W'(1'b1);
              end
            end
          end
          default: begin
            state_r   <= OFF;
            idx_r     <= IDX_W'(1'b0);
            dig_sel_r <= {NDIG{1'b0}};
          end
        endcase
      end
    end
  end

  assign wr.wr_ready = wr_ready_r;
  assign dec_nib     = dec_nib_r;
  assign dig_sel     = dig_sel_r;
  assign frame_done  = frame_done_r;
endmodule
